// File: rtl/section_termination_multi.sv
// Backward-metric termination over K tail trellis steps of an 8-state RSC code.
// Optional sticky positive-saturation flag port Sat: define SECTION_TERM_SAT_FLAG_EN.
module section_termination_multi #(
  parameter int unsigned N = 6,
  parameter int unsigned M = 6,
  parameter int unsigned K = 3
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Clear,
  input  logic                 Enable,
  input  logic                 Start,
  input  logic [K-1:0][N-1:0]  ba1,
  input  logic [K-1:0][N-1:0]  ba2,
  output logic                 Busy,
  output logic                 Valid,
  output logic [7:1][M-1:0]    beta_out
`ifdef SECTION_TERM_SAT_FLAG_EN
  ,
  output logic                 Sat
`endif
);

  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned SW = ((M > N + 1) ? M : N + 1) + 1;
  localparam int MAXV = (1 << (M - 1)) - 1;
  localparam int MINV = -(1 << (M - 1));
  localparam logic signed [SW-1:0] SMAX = SW'(MAXV);
  localparam logic signed [SW-1:0] SMIN = SW'(MINV);
  localparam logic signed [M-1:0]  BMAX = M'(MAXV);
  localparam logic signed [M-1:0]  BMIN = M'(MINV);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                 state_q;
  logic [CW-1:0]          step_q;
  logic [K-1:0][N-1:0]    ba1_q;
  logic [K-1:0][N-1:0]    ba2_q;
  logic signed [M-1:0]    b_q [1:7];
  logic signed [M-1:0]    b_d [1:7];
  logic [7:1][M-1:0]      beta_q;
  logic                   busy_q;
  logic                   valid_q;

  logic signed [N:0]      a1_c;
  logic signed [N:0]      a2_c;
  logic signed [M-1:0]    bx_c [0:7];
  logic signed [N:0]      g_c [1:7];
  logic signed [SW-1:0]   sum_c [1:7];
  logic [2:0]             sv_c;
`ifdef SECTION_TERM_SAT_FLAG_EN
  logic                   pos_sat_c;
  logic                   sat_q;
`endif

  function automatic logic signed [M-1:0] sat_m(input logic signed [SW-1:0] x);
    if (x > SMAX)      sat_m = BMAX;
    else if (x < SMIN) sat_m = BMIN;
    else               sat_m = M'(x);
  endfunction

  // One backward trellis step on the current tail LLR pair; state 0 is the fixed reference.
  always_comb begin
    a1_c  = (N+1)'($signed(ba1_q[step_q]));
    a2_c  = (N+1)'($signed(ba2_q[step_q]));
    sv_c  = '0;
    bx_c[0] = '0;
    for (int s = 1; s < 8; s++) bx_c[s] = b_q[s];
`ifdef SECTION_TERM_SAT_FLAG_EN
    pos_sat_c = 1'b0;
`endif
    for (int s = 1; s < 8; s++) begin
      sv_c     = 3'(s);
      g_c[s]   = ((sv_c[1] ^ sv_c[0]) ? a1_c : '0) + ((sv_c[2] ^ sv_c[0]) ? a2_c : '0);
      sum_c[s] = SW'(bx_c[{1'b0, sv_c[2:1]}]) + SW'(g_c[s]);
      b_d[s]   = sat_m(sum_c[s]);
`ifdef SECTION_TERM_SAT_FLAG_EN
      pos_sat_c = pos_sat_c | (sum_c[s] > SMAX);
`endif
    end
  end

  // Pass control: latch tail LLRs, walk steps K-1..0, then publish the metrics.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      ba1_q   <= '0;
      ba2_q   <= '0;
      beta_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 1; i < 8; i++) b_q[i] <= BMIN;
`ifdef SECTION_TERM_SAT_FLAG_EN
      sat_q   <= 1'b0;
`endif
    end else if (Clear) begin
      state_q <= IDLE;
      beta_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 1; i < 8; i++) b_q[i] <= BMIN;
`ifdef SECTION_TERM_SAT_FLAG_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      // Valid is a strict one-cycle pulse, independent of Enable
      valid_q <= 1'b0;
      if (Enable) begin
        case (state_q)
          IDLE: begin
            if (Start) begin
              ba1_q   <= ba1;
              ba2_q   <= ba2;
              step_q  <= CW'(K - 1);
              state_q <= RUN;
              busy_q  <= 1'b1;
              for (int i = 1; i < 8; i++) b_q[i] <= BMIN;
`ifdef SECTION_TERM_SAT_FLAG_EN
              sat_q   <= 1'b0;
`endif
            end
          end
          RUN: begin
            for (int i = 1; i < 8; i++) b_q[i] <= b_d[i];
`ifdef SECTION_TERM_SAT_FLAG_EN
            sat_q <= sat_q | pos_sat_c;
`endif
            if (step_q == '0) state_q <= DONE;
            else              step_q  <= step_q - 1'b1;
          end
          DONE: begin
            for (int i = 1; i < 8; i++) beta_q[i] <= b_q[i];
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Busy     = busy_q;
  assign Valid    = valid_q;
  assign beta_out = beta_q;
`ifdef SECTION_TERM_SAT_FLAG_EN
  assign Sat      = sat_q;
`endif

endmodule
